// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter and its baud generator.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with synchronous clear; tick marks the final cycle of each bit.
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == TERMINAL);

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops words, retries pops lost to same-cycle writes, serialises LSB first.
// Optional even-parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int data_width   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_en,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(data_width + 1);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(data_width - 1);
  localparam logic [BW-1:0] LAST_STOP_BIT = BW'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  baud_clear, baud_tick, pop_honoured, start_ok;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // The FIFO gives a simultaneous write priority, so a pop only lands if no write is accepted.
  assign pop_honoured = fifo_rd_en & ~fifo_empty & ~(fifo_wr_en & ~fifo_full);
  assign start_ok     = tx_en & ~fifo_empty;
  assign fifo_rd_en   = (state_q == REQ);
  assign busy         = (state_q != IDLE);
  assign baud_clear   = (state_q == IDLE) | (state_q == REQ) | (state_q == LOAD);
  assign frame_done   = (state_q == STOP) & baud_tick & (bit_cnt_q == LAST_STOP_BIT);
  assign txd          = txd_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // txd_d is the line level for the state being entered, keeping txd a pure register.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = TXD_IDLE;
        if (start_ok) state_d = REQ;
      end
      REQ: begin
        if (fifo_empty)        state_d = IDLE;
        else if (pop_honoured) state_d = LOAD;
      end
      LOAD: begin
        shift_d   = fifo_data;
        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        txd_d     = TXD_START;
        state_d   = START;
      end
      START: begin
        if (baud_tick) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_DATA_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            txd_d     = parity_q;
            state_d   = PARITY;
`else
            txd_d     = TXD_IDLE;
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          txd_d   = TXD_IDLE;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_STOP_BIT) begin
            bit_cnt_d = '0;
            state_d   = start_ok ? REQ : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        txd_d   = TXD_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= TXD_IDLE;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
